// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read port.
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = 12,
  parameter int unsigned AE_THRESH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Requests are qualified only by the registered occupancy
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign count        = count_q;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == CNT_W'(0));
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

  // Storage is not reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; rd_en acknowledges it
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  logic [DATA_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (rd_acc) begin
      data_out_q <= mem[rd_ptr];
    end
  end

  assign data_out = data_out_q;
`endif

endmodule
